// File: rtl/bank_access_arbiter_if.sv
// Request/grant bundle between the requesting masters and the banked-memory arbiter.
// Every field is per-port and packed. Port p occupies [p*W +: W] for its field width W.
interface bank_access_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_BANKS  = 4,
    parameter int NUM_PORTS  = 3
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    // Handshake: req is the valid and gnt is the ready. A port keeps req, we,
    // bank_sel, addr and din stable until it sees gnt. The access happens on the
    // rising edge where req & gnt are both 1. gnt is combinational and is never
    // 1 without req. rvalid pulses for one cycle, one cycle after a read grant.
    logic [NUM_PORTS-1:0]            req;
    logic [NUM_PORTS-1:0]            we;
    logic [NUM_PORTS*BANK_W-1:0]     bank_sel;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] din;
    logic [NUM_PORTS-1:0]            gnt;
    logic [NUM_PORTS-1:0]            rvalid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] dout;

    modport master (output req, we, bank_sel, addr, din, input gnt, rvalid, dout);
    modport slave  (input req, we, bank_sel, addr, din, output gnt, rvalid, dout);
endinterface

// File: rtl/bank_access_arbiter.sv
// Banked memory shared by NUM_PORTS requesters. Each bank has its own round-robin
// arbiter, so only requests that target the same bank are serialised.
module bank_access_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_BANKS  = 4,
    parameter int NUM_PORTS  = 3
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    bank_access_arbiter_if.slave                     bus,
    output logic [NUM_BANKS*$clog2(NUM_PORTS)-1:0]   o_dbg_ptr
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    logic [PORT_W-1:0]               r_ptr [NUM_BANKS];
    logic [NUM_PORTS-1:0]            r_rvalid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] r_dout;
    logic [DATA_WIDTH-1:0]           r_mem [NUM_BANKS][DEPTH];

    logic [PORT_W-1:0]               w_win [NUM_BANKS];
    logic [NUM_BANKS-1:0]            w_win_vld;
    logic [NUM_PORTS-1:0]            w_gnt;

    // Per bank: the first requester at or after the pointer, wrapping modulo NUM_PORTS.
    always_comb begin : arbitrate
        int idx;
        idx = 0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_win_vld[b] = 1'b0;
            w_win[b]     = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = (int'(r_ptr[b]) + k) % NUM_PORTS;
                if (!w_win_vld[b] && bus.req[idx] &&
                    bus.bank_sel[idx*BANK_W +: BANK_W] == BANK_W'(b)) begin
                    w_win_vld[b] = 1'b1;
                    w_win[b]     = PORT_W'(idx);
                end
            end
        end
    end

    // A port selects exactly one bank, so it can win at most one arbiter.
    always_comb begin
        w_gnt = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_win_vld[b]) w_gnt[w_win[b]] = 1'b1;
        end
        if (!rst_n) w_gnt = '0;
    end

    // The storage is not reset. Writes are held off while rst_n is low.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rst_n && w_win_vld[b] && bus.we[w_win[b]]) begin
                r_mem[b][bus.addr[w_win[b]*ADDR_WIDTH +: ADDR_WIDTH]]
                    <= bus.din[w_win[b]*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= '0;
            r_dout   <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_rvalid[p] <= w_gnt[p] && !bus.we[p];
                if (w_gnt[p] && !bus.we[p]) begin
                    r_dout[p*DATA_WIDTH +: DATA_WIDTH]
                        <= r_mem[bus.bank_sel[p*BANK_W +: BANK_W]][bus.addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) r_ptr[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_win_vld[b]) begin
                    r_ptr[b] <= (w_win[b] == PORT_W'(NUM_PORTS - 1)) ? '0 : w_win[b] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_dbg_ptr = '0;
        for (int b = 0; b < NUM_BANKS; b++) o_dbg_ptr[b*PORT_W +: PORT_W] = r_ptr[b];
    end

    assign bus.gnt    = w_gnt;
    assign bus.rvalid = r_rvalid;
    assign bus.dout   = r_dout;
endmodule
